pipe_function_unit: RTL

- Parametrised, registered successor to the datapath function unit.
- Takes a (A, B, SH, FS) operation through a valid/ready handshake and computes it in one cycle, or iteratively for shifts.
- Presents result F and flags Z/C/N/V in a one-deep output register with its own valid/ready handshake.
- Sits between the register-file read stage and writeback; stalls upstream while a multi-cycle shift runs.

---
 rtl/fu_pkg.sv | 41 ++++
 rtl/fu_shift_step.sv | 46 ++++
 rtl/pipe_function_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fu_pkg.sv
// rtl/fu_pkg.sv - opcodes, FSM states and flag bundle shared by the function unit.
// FU_ROTATE_EN adds ROL/ROR to the set of multi-cycle shift opcodes.
package fu_pkg;

  localparam logic [4:0] FS_MOV     = 5'b00000;
  localparam logic [4:0] FS_MOV_ALT = 5'b00111;
  localparam logic [4:0] FS_ADD     = 5'b00010;
  localparam logic [4:0] FS_ADC     = 5'b00011;
  localparam logic [4:0] FS_SUB     = 5'b00101;
  localparam logic [4:0] FS_AND     = 5'b01000;
  localparam logic [4:0] FS_OR      = 5'b01010;
  localparam logic [4:0] FS_XOR     = 5'b01100;
  localparam logic [4:0] FS_NOT     = 5'b01110;
  localparam logic [4:0] FS_SLL     = 5'b10000;
  localparam logic [4:0] FS_SRL     = 5'b10001;
  localparam logic [4:0] FS_SRA     = 5'b10010;
  localparam logic [4:0] FS_ROL     = 5'b10011;
  localparam logic [4:0] FS_ROR     = 5'b10100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } fu_state_e;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } fu_flags_t;

  function automatic logic is_shift_fs(input logic [4:0] fs);
    logic hit;
    hit = (fs == FS_SLL) || (fs == FS_SRL) || (fs == FS_SRA);
`ifdef FU_ROTATE_EN
    hit = hit || (fs == FS_ROL) || (fs == FS_ROR);
`endif
    return hit;
  endfunction

endpackage

// File: rtl/fu_shift_step.sv
// rtl/fu_shift_step.sv - one-bit shift/rotate of the working word; FU_ROTATE_EN enables ROL/ROR.
module fu_shift_step
  import fu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [4:0]       fs,
  output logic [WIDTH-1:0] next_word,
  output logic             out_bit
);

  always_comb begin
    next_word = word;
    out_bit   = 1'b0;
    case (fs)
      FS_SLL: begin
        next_word = {word[WIDTH-2:0], 1'b0};
        out_bit   = word[WIDTH-1];
      end
      FS_SRL: begin
        next_word = {1'b0, word[WIDTH-1:1]};
        out_bit   = word[0];
      end
      FS_SRA: begin
        next_word = {word[WIDTH-1], word[WIDTH-1:1]};
        out_bit   = word[0];
      end
`ifdef FU_ROTATE_EN
      FS_ROL: begin
        next_word = {word[WIDTH-2:0], word[WIDTH-1]};
        out_bit   = word[WIDTH-1];
      end
      FS_ROR: begin
        next_word = {word[0], word[WIDTH-1:1]};
        out_bit   = word[0];
      end
`endif
      default: begin
        next_word = word;
        out_bit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_function_unit.sv
// rtl/pipe_function_unit.sv - handshaked ALU with one-deep result register and iterative shifter.
// FU_ROTATE_EN adds multi-cycle ROL/ROR; otherwise those opcodes report ILLEGAL.
module pipe_function_unit
  import fu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SH_W  = 5
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SH_W-1:0]  SH,
  input  logic [4:0]       FS,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] F,
  output logic             Z_OUT,
  output logic             C_OUT,
  output logic             N_OUT,
  output logic             V_OUT,
  output logic             ILLEGAL
);

  fu_state_e        state;
  logic [WIDTH-1:0] work;
  logic [SH_W-1:0]  cnt;
  logic [4:0]       fs_reg;
  logic             carry_reg;

  logic             out_valid;
  logic [WIDTH-1:0] out_f;
  fu_flags_t        out_flags;
  logic             out_illegal;

  logic             out_free;
  logic             in_ready;
  logic             accept;
  logic             multi;

  logic [WIDTH-1:0] acc_next;
  logic             acc_out;
  logic [WIDTH-1:0] run_next;
  logic             run_out;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_f;
  logic             res_c;
  logic             res_v;
  logic             res_ill;
  logic             res_arith;
  fu_flags_t        res_flags;
  fu_flags_t        fin_flags;

  assign out_free = !out_valid || OUT_READY;
  assign in_ready = (state == ST_IDLE) && out_free;
  assign accept   = IN_VALID && in_ready;
  assign multi    = is_shift_fs(FS) && (SH > SH_W'(1));

  // First step is taken from A at acceptance, later steps from the working register.
  fu_shift_step #(.WIDTH(WIDTH)) u_step_in (
    .word      (A),
    .fs        (FS),
    .next_word (acc_next),
    .out_bit   (acc_out)
  );

  fu_shift_step #(.WIDTH(WIDTH)) u_step_run (
    .word      (work),
    .fs        (fs_reg),
    .next_word (run_next),
    .out_bit   (run_out)
  );

  always_comb begin
    sum       = '0;
    res_f     = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    res_ill   = 1'b0;
    res_arith = 1'b0;
    if (is_shift_fs(FS)) begin
      if (SH != '0) begin
        res_f = acc_next;
        res_c = acc_out;
      end else begin
        res_f = A;
      end
    end else begin
      case (FS)
        FS_MOV, FS_MOV_ALT: res_f = A;
        FS_ADD, FS_ADC: begin
          sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, (FS == FS_ADC) && carry_reg};
          res_f     = sum[WIDTH-1:0];
          res_c     = sum[WIDTH];
          res_v     = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
          res_arith = 1'b1;
        end
        FS_SUB: begin
          // Carry out of A + ~B + 1 is the inverted borrow.
          sum       = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
          res_f     = sum[WIDTH-1:0];
          res_c     = sum[WIDTH];
          res_v     = (A[WIDTH-1] != B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
          res_arith = 1'b1;
        end
        FS_AND:  res_f = A & B;
        FS_OR:   res_f = A | B;
        FS_XOR:  res_f = A ^ B;
        FS_NOT:  res_f = ~A;
        default: res_ill = 1'b1;
      endcase
    end
    res_flags = '{z: (res_f == '0), c: res_c, n: res_f[WIDTH-1], v: res_v};
    fin_flags = '{z: (run_next == '0), c: run_out, n: run_next[WIDTH-1], v: 1'b0};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      work        <= '0;
      cnt         <= '0;
      fs_reg      <= '0;
      carry_reg   <= 1'b0;
      out_valid   <= 1'b0;
      out_f       <= '0;
      out_flags   <= '0;
      out_illegal <= 1'b0;
    end else begin
      if (out_valid && OUT_READY) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (multi) begin
              work   <= acc_next;
              cnt    <= SH - SH_W'(1);
              fs_reg <= FS;
              state  <= ST_SHIFT;
            end else begin
              out_valid   <= 1'b1;
              out_f       <= res_f;
              out_flags   <= res_flags;
              out_illegal <= res_ill;
              if (res_arith) begin
                carry_reg <= res_c;
              end
            end
          end
        end
        ST_SHIFT: begin
          // The last step waits here until the result register can take it.
          if (cnt == SH_W'(1)) begin
            if (out_free) begin
              out_valid   <= 1'b1;
              out_f       <= run_next;
              out_flags   <= fin_flags;
              out_illegal <= 1'b0;
              state       <= ST_IDLE;
            end
          end else begin
            work <= run_next;
            cnt  <= cnt - SH_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = out_valid;
  assign F         = out_f;
  assign Z_OUT     = out_flags.z;
  assign C_OUT     = out_flags.c;
  assign N_OUT     = out_flags.n;
  assign V_OUT     = out_flags.v;
  assign ILLEGAL   = out_illegal;

endmodule
